// File: rtl/nios_mul_pkg.sv
// Shared op encoding and sequencer state type for the multiply sequencer.
package nios_mul_pkg;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXUU = 2'd1;
    localparam logic [1:0] OP_MULXSS = 2'd2;
    localparam logic [1:0] OP_MULXSU = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE1,
        ST_COLLECT1,
        ST_ISSUE2,
        ST_COLLECT2,
        ST_DONE
    } state_t;

endpackage

// File: rtl/nios_mul_sum.sv
// Combines the cell partial products into the low word (MUL) or the
// high word with optional two's-complement correction (MULX*).
module nios_mul_sum
    import nios_mul_pkg::*;
#(
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] ll,
    input  logic [31:0] lh,
    input  logic [31:0] hl,
    input  logic [31:0] hh,
    output logic [31:0] result
);

    logic [32:0] mid;
    logic [63:0] u;
    logic [31:0] corr_a;
    logic [31:0] corr_b;

    always_comb begin
        mid    = {1'b0, lh} + {1'b0, hl};
        u      = {32'h0, ll} + {15'h0, mid, 16'h0} + {hh, 32'h0};
        // Signed high word = unsigned high word minus the sign-weighted cross terms.
        corr_a = (SIGNED_EN && a[31]) ? b : 32'h0;
        corr_b = (SIGNED_EN && b[31]) ? a : 32'h0;
        result = u[63:32];
        case (op)
            OP_MUL:    result = u[31:0];
            OP_MULXUU: result = u[63:32];
            OP_MULXSS: result = u[63:32] - corr_a - corr_b;
            default:   result = u[63:32] - corr_a;
        endcase
    end

endmodule

// File: rtl/nios_mul_seq.sv
// Sequences the 16x16 multiply cell (one or two passes) and registers the
// combined product word.
//   state    | meaning
//   IDLE     | waiting for start
//   ISSUE1   | full operands to cell, cell_en=1
//   COLLECT1 | capture ll/lh/hl; MUL finishes here
//   ISSUE2   | high halves to cell for a_hi*b_hi
//   COLLECT2 | capture hh
//   DONE     | done strobe, result valid
module nios_mul_seq
    import nios_mul_pkg::*;
#(
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        kill,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    state_t      state, next_state;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q, ll_q, lh_q, hl_q, hh_q;
    logic [31:0] sum_ll, sum_lh, sum_hl, sum_hh, sum_res;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (start && !kill) next_state = ST_ISSUE1;
            ST_ISSUE1:   next_state = ST_COLLECT1;
            ST_COLLECT1: next_state = (op_q == OP_MUL) ? ST_DONE : ST_ISSUE2;
            ST_ISSUE2:   next_state = ST_COLLECT2;
            ST_COLLECT2: next_state = ST_DONE;
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
        if (kill && state != ST_IDLE && state != ST_DONE) next_state = ST_IDLE;
    end

    assign cell_en = (state == ST_ISSUE1) || (state == ST_ISSUE2);
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

    // Result is loaded on the edge entering DONE, so the collect states feed
    // the adder straight from the cell outputs.
    assign sum_ll = (state == ST_COLLECT1) ? cell_p1 : ll_q;
    assign sum_lh = (state == ST_COLLECT1) ? cell_p2 : lh_q;
    assign sum_hl = (state == ST_COLLECT1) ? cell_p3 : hl_q;
    assign sum_hh = (state == ST_COLLECT2) ? cell_p1 : hh_q;

    nios_mul_sum #(.SIGNED_EN(SIGNED_EN)) u_sum (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .ll     (sum_ll),
        .lh     (sum_lh),
        .hl     (sum_hl),
        .hh     (sum_hh),
        .result (sum_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= 2'd0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            ll_q      <= 32'h0;
            lh_q      <= 32'h0;
            hl_q      <= 32'h0;
            hh_q      <= 32'h0;
            cell_src1 <= 32'h0;
            cell_src2 <= 32'h0;
            result    <= 32'h0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && next_state == ST_ISSUE1) begin
                op_q      <= op;
                a_q       <= src_a;
                b_q       <= src_b;
                cell_src1 <= src_a;
                cell_src2 <= src_b;
            end
            if (state == ST_COLLECT1) begin
                ll_q <= cell_p1;
                lh_q <= cell_p2;
                hl_q <= cell_p3;
            end
            if (next_state == ST_ISSUE2) begin
                cell_src1 <= {16'h0, a_q[31:16]};
                cell_src2 <= {16'h0, b_q[31:16]};
            end
            if (state == ST_COLLECT2) hh_q <= cell_p1;
            if (next_state == ST_DONE) result <= sum_res;
        end
    end

endmodule

// File: tb/tb_nios_mul_seq.sv
// Directed and random checks of nios_mul_seq against a plain 64-bit
// arithmetic model, with a behavioural 16x16 multiply cell.
module tb_nios_mul_seq;
    import nios_mul_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src_a = 32'h0;
    logic [31:0] src_b = 32'h0;
    logic [31:0] cell_src1, cell_src2, result;
    logic [31:0] cell_p1, cell_p2, cell_p3;
    logic        cell_en, busy, done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nios_mul_seq #(.SIGNED_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .kill      (kill),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    // Multiply cell: registered a_lo*b_lo, a_lo*b_hi, a_hi*b_lo.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cell_p1 <= 32'h0;
            cell_p2 <= 32'h0;
            cell_p3 <= 32'h0;
        end else if (cell_en) begin
            cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
            cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
            cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
        end
    end

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (o)
            OP_MULXSS: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            OP_MULXSU: p = {{32{a[31]}}, a} * {32'h0, b};
            default:   p = {32'h0, a} * {32'h0, b};
        endcase
        return (o == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Cycle 0 is the cycle start is high; observation is at each negedge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke_n, input int kill_n,
                          output int dcnt, output int lat, output logic [31:0] res, output bit gap);
        dcnt = 0;
        lat  = -1;
        res  = 32'h0;
        gap  = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            if (done) begin
                dcnt++;
                if (lat < 0) begin
                    lat = n;
                    res = result;
                end
            end
            if (!busy && lat < 0) gap = 1'b1;
            start = (n == poke_n);
            if (n == poke_n) begin
                op    = ~o;
                src_a = a ^ 32'h1234_5678;
                src_b = ~b;
            end
            kill = (n == kill_n);
            @(negedge clk);
        end
        start = 1'b0;
        kill  = 1'b0;
    endtask

    task automatic full_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b, input int poke_n, input int kill_n);
        int dcnt, lat;
        logic [31:0] res;
        bit gap;
        run_op(o, a, b, poke_n, kill_n, dcnt, lat, res, gap);
        chk({tag, "_result"}, res, model(o, a, b));
        chk({tag, "_latency"}, 32'(lat), (o == OP_MUL) ? 32'd3 : 32'd5);
        chk({tag, "_done_count"}, 32'(dcnt), 32'd1);
        chk({tag, "_busy_gap"}, {31'h0, gap}, 32'd0);
    endtask

    initial begin
        int dcnt, lat;
        logic [31:0] res;
        bit gap;
        logic [1:0] ro;
        logic [31:0] ra, rb;

        @(negedge clk);
        chk("reset_busy", {31'h0, busy}, 32'd0);
        chk("reset_done", {31'h0, done}, 32'd0);
        chk("reset_cell_en", {31'h0, cell_en}, 32'd0);
        chk("reset_result", result, 32'h0);
        chk("reset_cell_src1", cell_src1, 32'h0);
        reset = 1'b0;

        full_check("mul_basic", OP_MUL, 32'h0001_0003, 32'h0002_0005, 0, 0);
        chk("mul_basic_p1", cell_p1, 32'd15);
        chk("mul_basic_p2", cell_p2, 32'd6);
        chk("mul_basic_p3", cell_p3, 32'd5);
        chk("mul_basic_value", result, 32'h000B_000F);

        full_check("mulxuu_basic", OP_MULXUU, 32'h0001_0003, 32'h0002_0005, 0, 0);
        chk("mulxuu_basic_hh", cell_p1, 32'd2);
        chk("mulxuu_basic_value", result, 32'h0000_0002);

        full_check("mulxuu_ones", OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("mulxuu_ones_value", result, 32'hFFFF_FFFE);
        full_check("mulxss_ones", OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("mulxss_ones_value", result, 32'h0000_0000);
        full_check("mulxsu_m1x2", OP_MULXSU, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
        chk("mulxsu_m1x2_value", result, 32'hFFFF_FFFF);

        full_check("start_while_busy", OP_MULXUU, 32'h0001_0003, 32'h0002_0005, 2, 0);
        full_check("start_in_done", OP_MUL, 32'h0000_0011, 32'h0000_0013, 3, 0);

        run_op(OP_MULXUU, 32'hABCD_1234, 32'h5678_9ABC, 0, 3, dcnt, lat, res, gap);
        chk("kill_issue2_done_count", 32'(dcnt), 32'd0);
        chk("kill_issue2_result_held", result, 32'd323);
        chk("kill_issue2_idle", {31'h0, busy}, 32'd0);

        full_check("kill_in_done", OP_MUL, 32'd7, 32'd6, 0, 3);
        chk("kill_in_done_value", result, 32'd42);

        @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_idle_busy", {31'h0, busy}, 32'd0);
        chk("kill_idle_result", result, 32'd42);

        @(negedge clk);
        start = 1'b1; op = OP_MUL; src_a = 32'd5; src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_busy", {31'h0, busy}, 32'd0);
        chk("async_reset_done", {31'h0, done}, 32'd0);
        chk("async_reset_cell_en", {31'h0, cell_en}, 32'd0);
        chk("async_reset_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        full_check("after_reset_mul", OP_MUL, 32'd3, 32'd3, 0, 0);
        chk("after_reset_value", result, 32'd9);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) ra = {1'b1, ra[30:0]};
            if (i % 7 == 0) rb = {1'b1, rb[30:0]};
            full_check($sformatf("random_%0d", i), ro, ra, rb, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
